// File: rtl/msg_schedule.sv
// msg_schedule: SHA-256 message-schedule stage.
// Takes one padded 512-bit block and streams W[0]..W[NUMBER_OF_Ks-1] one word
// per accepted cycle, using a 16-word sliding window and a single sigma adder tree.
// Optional build macro: MSG_SCHED_BSWAP_EN byte-reverses every 32-bit word at
// load time, for padding stages that pack bytes little-endian within a word.
module msg_schedule #(
    parameter int NUMBER_OF_Ks = 64,
    parameter int WORD_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  blk_valid,
    input  logic [511:0]          blk_data,
    output logic                  blk_ready,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [WORD_WIDTH-1:0] w_data,
    output logic [5:0]            w_index,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_T = 6'(NUMBER_OF_Ks - 1);

    state_t                state;
    logic [WORD_WIDTH-1:0] window [16];
    logic [5:0]            t;
    logic [WORD_WIDTH-1:0] next_word;

    // Small sigma: rotate-right 7 and 18, shift-right 3.
    function automatic logic [WORD_WIDTH-1:0] sigma0(input logic [WORD_WIDTH-1:0] x);
        return ((x >> 7)  | (x << (WORD_WIDTH - 7)))  ^
               ((x >> 18) | (x << (WORD_WIDTH - 18))) ^
               (x >> 3);
    endfunction

    // Small sigma: rotate-right 17 and 19, shift-right 10.
    function automatic logic [WORD_WIDTH-1:0] sigma1(input logic [WORD_WIDTH-1:0] x);
        return ((x >> 17) | (x << (WORD_WIDTH - 17))) ^
               ((x >> 19) | (x << (WORD_WIDTH - 19))) ^
               (x >> 10);
    endfunction

    // Word conditioning applied as the block is loaded into the window.
    function automatic logic [WORD_WIDTH-1:0] load_word(input logic [WORD_WIDTH-1:0] x);
`ifdef MSG_SCHED_BSWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    // Next schedule word entering the top of the window: W[t+16] from W[t..t+14].
    always_comb begin
        next_word = sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0];
    end

    // The current word always sits at the bottom of the window; index follows t.
    assign w_data  = window[0];
    assign w_index = t;

    // Control FSM plus window/counter update; handshake outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            blk_ready <= 1'b1;
            w_valid   <= 1'b0;
            done      <= 1'b0;
            t         <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                window[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        for (int j = 0; j < 16; j++) begin
                            window[j] <= load_word(blk_data[511 - 32*j -: 32]);
                        end
                        t         <= 6'd0;
                        state     <= RUN;
                        blk_ready <= 1'b0;
                        w_valid   <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_ready) begin
                        if (t == LAST_T) begin
                            // Last word leaves the window untouched so it stays visible.
                            state   <= DONE;
                            w_valid <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            for (int k = 0; k < 15; k++) begin
                                window[k] <= window[k + 1];
                            end
                            window[15] <= next_word;
                            t          <= t + 6'd1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    blk_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    blk_ready <= 1'b1;
                    w_valid   <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_schedule.sv
// tb_msg_schedule: self-checking bench for msg_schedule.
// Expected words come from a plain SHA-256 schedule model computed over the
// whole block, plus known-answer values for the "abc" block.
module tb_msg_schedule;

    localparam int K = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_ready;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_index;
    logic         done;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] exp_w [K];
    logic [31:0] got_w [K];

    typedef struct {
        string        name;
        logic [511:0] blk;
        int           ready_mode;
        bit           interfere;
        bit           kat;
    } case_t;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } kat_t;

    case_t cases [8];
    kat_t  abc_kat [5];
    logic [511:0] abc_blk;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    msg_schedule #(.NUMBER_OF_Ks(K), .WORD_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .blk_ready (blk_ready),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_index   (w_index),
        .done      (done)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [511:0] randomBlock();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) begin
            b[32*i +: 32] = $urandom;
        end
        return b;
    endfunction

    // Reference: full 64-word schedule from the block, by the textbook recurrence.
    task automatic buildModel(input logic [511:0] blk);
        logic [31:0] wd;
        for (int j = 0; j < 16; j++) begin
            wd = blk[511 - 32*j -: 32];
`ifdef MSG_SCHED_BSWAP_EN
            wd = bswap(wd);
`endif
            exp_w[j] = wd;
        end
        for (int i = 16; i < K; i++) begin
            exp_w[i] = s1(exp_w[i-2]) + exp_w[i-7] + s0(exp_w[i-15]) + exp_w[i-16];
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic readyFor(input int mode, input int p);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (p % 4 == 0) || (p % 4 == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    // Loads one block, drains all words with the chosen ready pattern, checks done/handoff.
    task automatic applyStimulus(input logic [511:0] blk, input int mode, input bit interfere);
        int waitc;
        int count;
        int cycles;
        int p;
        logic r;
        buildModel(blk);
        waitc = 0;
        while (!blk_ready && waitc < 10) begin
            tick();
            waitc++;
        end
        checkOutput("blk_ready_before_load", blk_ready, 1);
        blk_valid = 1'b1;
        blk_data  = blk;
        w_ready   = 1'b0;
        tick();
        blk_valid = 1'b0;
        checkOutput("blk_ready_in_run", blk_ready, 0);
        count  = 0;
        cycles = 0;
        p      = 0;
        while (count < K && cycles < K * 8) begin
            checkOutput("w_valid_in_run", w_valid, 1);
            checkOutput("w_data", w_data, exp_w[count]);
            checkOutput("w_index", w_index, count);
            checkOutput("done_in_run", done, 0);
            r = readyFor(mode, p);
            p++;
            w_ready = r;
            if (interfere) begin
                blk_valid = 1'b1;
                blk_data  = randomBlock();
            end
            if (r) begin
                got_w[count] = w_data;
                count++;
            end
            tick();
            cycles++;
        end
        blk_valid = 1'b0;
        w_ready   = 1'b0;
        checkOutput("words_transferred", count, K);
        if (mode == 0) checkOutput("load_to_done_edges", cycles, K);
        checkOutput("done_pulse", done, 1);
        checkOutput("w_valid_in_done", w_valid, 0);
        checkOutput("blk_ready_in_done", blk_ready, 0);
        checkOutput("w_data_held_done", w_data, exp_w[K-1]);
        checkOutput("w_index_held_done", w_index, K - 1);
        tick();
        checkOutput("done_cleared", done, 0);
        checkOutput("blk_ready_after_done", blk_ready, 1);
        checkOutput("w_valid_idle", w_valid, 0);
        checkOutput("w_data_held_idle", w_data, exp_w[K-1]);
        checkOutput("w_index_held_idle", w_index, K - 1);
    endtask

    // Abandons an "abc" stream at t=20 with reset, then checks a fresh load.
    task automatic resetMidStream();
        buildModel(abc_blk);
        blk_valid = 1'b1;
        blk_data  = abc_blk;
        tick();
        blk_valid = 1'b0;
        w_ready   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checkOutput("pre_reset_w_data", w_data, exp_w[i]);
            tick();
        end
        checkOutput("pre_reset_w_index", w_index, 20);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        w_ready = 1'b0;
        checkOutput("mid_reset_blk_ready", blk_ready, 1);
        checkOutput("mid_reset_w_valid", w_valid, 0);
        checkOutput("mid_reset_w_data", w_data, 0);
        checkOutput("mid_reset_w_index", w_index, 0);
        checkOutput("mid_reset_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post_reset_no_done", done, 0);
            checkOutput("post_reset_idle", w_valid, 0);
        end
        applyStimulus(abc_blk, 0, 1'b0);
        for (int i = 0; i < K; i++) begin
            checkOutput("abc_after_reset_model", got_w[i], exp_w[i]);
        end
        checkOutput("abc_after_reset_W63", got_w[63], 32'h12B1EDEB);
    endtask

    initial begin
        reset     = 1'b1;
        blk_valid = 1'b0;
        blk_data  = '0;
        w_ready   = 1'b0;

        abc_blk = '0;
`ifdef MSG_SCHED_BSWAP_EN
        abc_blk[511 -: 32] = 32'h80636261;
        abc_blk[31:0]      = 32'h18000000;
`else
        abc_blk[511 -: 32] = 32'h61626380;
        abc_blk[31:0]      = 32'h00000018;
`endif

        abc_kat[0] = '{0,  32'h61626380};
        abc_kat[1] = '{15, 32'h00000018};
        abc_kat[2] = '{16, 32'h61626380};
        abc_kat[3] = '{17, 32'h000F0000};
        abc_kat[4] = '{63, 32'h12B1EDEB};

        cases[0] = '{"abc_full_rate",     abc_blk,       0, 1'b0, 1'b1};
        cases[1] = '{"zero_block",        512'd0,        0, 1'b0, 1'b0};
        cases[2] = '{"abc_toggle_ready",  abc_blk,       1, 1'b0, 1'b1};
        cases[3] = '{"abc_blk_valid_run", abc_blk,       0, 1'b1, 1'b1};
        cases[4] = '{"rand_full_rate",    randomBlock(), 0, 1'b0, 1'b0};
        cases[5] = '{"rand_rand_ready",   randomBlock(), 2, 1'b0, 1'b0};
        cases[6] = '{"rand_interfere",    randomBlock(), 2, 1'b1, 1'b0};
        cases[7] = '{"rand_toggle",       randomBlock(), 1, 1'b1, 1'b0};

        tick();
        tick();
        checkOutput("reset_blk_ready", blk_ready, 1);
        checkOutput("reset_w_valid", w_valid, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_w_data", w_data, 0);
        checkOutput("reset_w_index", w_index, 0);
        reset = 1'b0;
        tick();
        checkOutput("idle_blk_ready", blk_ready, 1);

        for (int c = 0; c < 8; c++) begin
            $display("[TB] case %s", cases[c].name);
            applyStimulus(cases[c].blk, cases[c].ready_mode, cases[c].interfere);
            if (cases[c].kat) begin
                for (int k = 0; k < 5; k++) begin
                    checkOutput($sformatf("%s_W%0d", cases[c].name, abc_kat[k].idx),
                                got_w[abc_kat[k].idx], abc_kat[k].val);
                end
            end
            tick();
        end

        $display("[TB] case reset_mid_stream");
        resetMidStream();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
